// File: rtl/my_pkg.sv
// Shared I2C types and constants for the memory-mapped I2C target.
package my_pkg;

  typedef logic [6:0] address_t;
  typedef logic [7:0] byte_t;
  typedef logic       ACKT_t;

  localparam int       I2C_BITS_PER_BYTE = 8;
  localparam address_t GEN_CALL_ADDR     = 7'h00;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } tgt_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_mem_target_if.sv
// Open-drain I2C pair as seen by the target, plus the ACKT indication.
interface i2c_mem_target_if;
  import my_pkg::*;

  logic  scl_i;
  logic  sda_i;
  logic  sda_oe;
  ACKT_t ACKT;

  modport master (output scl_i, sda_i, input sda_oe, ACKT);
  modport slave  (input scl_i, sda_i, output sda_oe, ACKT);

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, edge detect and START/STOP detection.
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter (+2 clk).
module i2c_bus_sync
  import my_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_prev, sda_prev;

  // Idle bus level is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_f    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  // START/STOP need SCL high in both samples, so an SDA change on an SCL edge is data.
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign sda_s     = sda_f;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

endmodule

// File: rtl/i2c_mem_target.sv
// I2C target with a byte-addressed register file: pointer write, burst write,
// and burst read with auto-increment.
module i2c_mem_target
  import my_pkg::*;
#(
  parameter address_t DEV_ADDR  = 7'h50,
  parameter int       MEM_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  i2c_mem_target_if.slave              bus,
  output logic                         wr_strobe,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output byte_t                        wr_data,
  output logic                         busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  typedef logic [AW-1:0] ptr_t;

  logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
  tgt_state_t state;
  byte_t      mem [MEM_DEPTH];
  byte_t      shreg, rx_byte;
  logic [3:0] bit_cnt;
  ptr_t       ptr, ptr_inc;
  logic       rw, byte_done, addr_hit;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign rx_byte   = {shreg[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt == 4'(I2C_BITS_PER_BYTE - 1));
  assign addr_hit  = (rx_byte[7:1] == DEV_ADDR) && (DEV_ADDR != GEN_CALL_ADDR);
  assign ptr_inc   = ptr + ptr_t'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.ACKT   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      // NOTE: the register file must read as zero after reset, so it is reset here (flops, not a RAM macro).
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
        bus.ACKT   <= 1'b0;
        busy       <= 1'b0;
      end else if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
        bus.ACKT   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            if (byte_done) begin
              if (state == ADDR) begin
                state <= addr_hit ? ADDR_ACK : IGNORE;
                rw    <= rx_byte[0];
                if (addr_hit) busy <= 1'b1;
              end else if (state == PTR) begin
                ptr   <= rx_byte[AW-1:0];
                state <= PTR_ACK;
              end else begin
                mem[ptr]  <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                state     <= WDATA_ACK;
              end
            end
          end
          // ACKT doubles as the phase flag: first fall drives ACK, second fall ends it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            bus.ACKT <= ~bus.ACKT;
            if (!bus.ACKT) begin
              bus.sda_oe <= 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              shreg      <= mem[ptr];
              bus.sda_oe <= ~mem[ptr][7];
              state      <= RDATA;
            end else begin
              bus.sda_oe <= 1'b0;
              if (state == WDATA_ACK) ptr <= ptr_inc;
              state <= (state == ADDR_ACK) ? PTR : WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'(I2C_BITS_PER_BYTE)) begin
                bit_cnt    <= '0;
                bus.sda_oe <= 1'b0;
                state      <= RDATA_ACK;
              end else begin
                shreg      <= {shreg[6:0], 1'b0};
                bus.sda_oe <= ~shreg[6];
              end
            end
          end
          // bit_cnt=1 marks that the master ACKed and the next byte starts at this fall.
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              bit_cnt    <= '0;
              ptr        <= ptr_inc;
              shreg      <= mem[ptr_inc];
              bus.sda_oe <= ~mem[ptr_inc][7];
              state      <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_target.sv
// Self-checking bench: bit-banged I2C master plus a byte-array model of the register file.
module tb_i2c_mem_target;
  import my_pkg::*;

  localparam int       DEPTH = 16;
  localparam int       Q     = 50;
  localparam address_t DEV   = 7'h50;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic       wr_strobe, busy;
  logic [3:0] wr_addr;
  byte_t      wr_data;

  always #5 clk = ~clk;

  i2c_mem_target_if bus ();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_mem_target #(.DEV_ADDR(DEV), .MEM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int         st_cnt   = 0;
  int         oe_cnt   = 0;
  int         ackt_cnt = 0;
  int         busy_cnt = 0;
  logic [3:0] log_addr [256];
  byte_t      log_data [256];

  always @(negedge clk) begin
    if (wr_strobe) begin
      log_addr[st_cnt[7:0]] <= wr_addr;
      log_data[st_cnt[7:0]] <= wr_data;
      st_cnt <= st_cnt + 1;
    end
    if (bus.sda_oe) oe_cnt   <= oe_cnt + 1;
    if (bus.ACKT)   ackt_cnt <= ackt_cnt + 1;
    if (busy)       busy_cnt <= busy_cnt + 1;
  end

  byte_t model_mem [DEPTH];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [3:0] widx(input int p);
    return 4'(p % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    #Q;
  endtask

  task automatic clock_bit(input logic b, output logic seen, output logic ackt_seen);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    seen      = bus.sda_i;
    ackt_seen = bus.ACKT;
    #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input byte_t b, output logic ack, output logic ackt_seen);
    logic s, a;
    for (int i = 0; i < 8; i++) begin
      clock_bit(b[7], s, a);
      b = b << 1;
    end
    clock_bit(1'b1, s, a);
    ack       = ~s;
    ackt_seen = a;
  endtask

  task automatic read_byte(input logic nack, output byte_t d);
    logic s, a;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s, a);
      d = {d[6:0], s};
    end
    clock_bit(nack, s, a);
  endtask

  task automatic do_write(input byte_t ptr_b, input byte_t data [$]);
    logic ack, at;
    int   base;
    base = st_cnt;
    start_cond();
    write_byte({DEV, 1'b0}, ack, at);
    check("wr addr ack", 32'(ack), 1);
    check("wr addr ackt", 32'(at), 1);
    check("wr busy", 32'(busy), 1);
    write_byte(ptr_b, ack, at);
    check("wr ptr ack", 32'(ack), 1);
    foreach (data[i]) begin
      write_byte(data[i], ack, at);
      check("wr data ack", 32'(ack), 1);
      model_mem[widx(int'(ptr_b) + i)] = data[i];
    end
    stop_cond();
    repeat (6) @(negedge clk);
    check("wr strobe count", st_cnt - base, data.size());
    for (int i = 0; i < data.size(); i++) begin
      check("wr strobe addr", 32'(log_addr[8'(base + i)]), 32'(widx(int'(ptr_b) + i)));
      check("wr strobe data", 32'(log_data[8'(base + i)]), 32'(data[i]));
    end
    check("wr busy after stop", 32'(busy), 0);
  endtask

  task automatic do_read(input byte_t ptr_b, input int n);
    logic  ack, at;
    byte_t d;
    int    base;
    base = st_cnt;
    start_cond();
    write_byte({DEV, 1'b0}, ack, at);
    check("rd addr ack", 32'(ack), 1);
    write_byte(ptr_b, ack, at);
    check("rd ptr ack", 32'(ack), 1);
    start_cond();
    write_byte({DEV, 1'b1}, ack, at);
    check("rd addr r ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check($sformatf("rd data ptr%0d", widx(int'(ptr_b) + i)), 32'(d),
            32'(model_mem[widx(int'(ptr_b) + i)]));
    end
    stop_cond();
    repeat (6) @(negedge clk);
    check("rd released", 32'(bus.sda_oe), 0);
    check("rd idle busy", 32'(busy), 0);
    check("rd no strobe", st_cnt - base, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_t wq [$];
    logic  ack, at, s, a;
    int    b_oe, b_at, b_st, b_bz, k, n;
    byte_t p;

    foreach (model_mem[i]) model_mem[i] = '0;

    // Outputs while held in reset
    #22;
    check("reset sda_oe", 32'(bus.sda_oe), 0);
    check("reset ackt", 32'(bus.ACKT), 0);
    check("reset strobe", 32'(wr_strobe), 0);
    check("reset busy", 32'(busy), 0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset wr_data", 32'(wr_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed write, then read it back through a repeated START
    wq = {};
    wq.push_back(8'h5A);
    do_write(8'h03, wq);
    do_read(8'h03, 1);

    // Address mismatch and general call are ignored entirely
    b_oe = oe_cnt; b_at = ackt_cnt; b_st = st_cnt; b_bz = busy_cnt;
    start_cond();
    write_byte(8'hA4, ack, at);
    check("mis addr ack", 32'(ack), 0);
    write_byte(8'hFF, ack, at);
    check("mis data ack", 32'(ack), 0);
    stop_cond();
    start_cond();
    write_byte(8'h00, ack, at);
    check("gencall ack", 32'(ack), 0);
    stop_cond();
    repeat (6) @(negedge clk);
    check("mis sda_oe cycles", oe_cnt - b_oe, 0);
    check("mis ackt cycles", ackt_cnt - b_at, 0);
    check("mis strobes", st_cnt - b_st, 0);
    check("mis busy cycles", busy_cnt - b_bz, 0);

    // Pointer wrap from the last register to 0
    wq = {};
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'h0F, wq);
    do_read(8'h0F, 2);

    // Partial byte before STOP is discarded
    wq = {};
    wq.push_back(8'h3C);
    do_write(8'h02, wq);
    b_st = st_cnt;
    start_cond();
    write_byte({DEV, 1'b0}, ack, at);
    check("part addr ack", 32'(ack), 1);
    write_byte(8'h02, ack, at);
    check("part ptr ack", 32'(ack), 1);
    clock_bit(1'b1, s, a);
    clock_bit(1'b1, s, a);
    clock_bit(1'b0, s, a);
    clock_bit(1'b0, s, a);
    stop_cond();
    repeat (6) @(negedge clk);
    check("part strobes", st_cnt - b_st, 0);
    do_read(8'h02, 1);

    // Randomized bursts against the model, including wrap-around and ignored pointer MSBs
    for (int it = 0; it < 4; it++) begin
      wq = {};
      n  = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
      p = 8'($urandom);
      do_write(p, wq);
      do_read(8'($urandom), int'($urandom_range(1, 5)));
    end

    // Asynchronous reset while the address ACK is being driven
    start_cond();
    p = {DEV, 1'b0};
    for (int i = 0; i < 8; i++) begin
      clock_bit(p[7], s, a);
      p = p << 1;
    end
    k = 0;
    while (bus.sda_oe !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst pre sda_oe", 32'(bus.sda_oe), 1);
    check("rst pre ackt", 32'(bus.ACKT), 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst async sda_oe", 32'(bus.sda_oe), 0);
    check("rst async ackt", 32'(bus.ACKT), 0);
    check("rst async busy", 32'(busy), 0);
    foreach (model_mem[i]) model_mem[i] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    stop_cond();
    wq = {};
    wq.push_back(8'hC3);
    do_write(8'h05, wq);
    do_read(8'h03, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
